qpsk_symbol_sync: RTL

- Symbol timing recovery and hard-decision slicer directly downstream of the carrier-recovery loop in the QPSK demodulator.
- Integrate-and-dump over one symbol period on derotated baseband I/Q, with a sign-based Gardner timing detector that stretches or shrinks the window by one sample.
- Emits Gray-coded dibits on a valid/ready interface, only after carrier lock has been qualified.

---
 rtl/qpsk_symbol_sync.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/qpsk_symbol_sync.sv
// qpsk_symbol_sync
//   Symbol timing recovery and hard-decision slicer for the QPSK demodulator.
//   Derotated I/Q is integrated over one symbol period and dumped. A sign-based
//   Gardner detector nudges the period by one sample. Dibits are emitted on a
//   valid/ready interface once carrier lock has been held for LOCK_CNT dumps.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   i_in, q_in     signed derotated baseband samples, consumed when sample_en=1
//   sample_en      sample strobe
//   carrier_locked lock flag from the carrier loop
//   sym_ready      downstream accept
//   sym_valid      symbol available (held until accepted)
//   sym_data       dibit {I<0, Q<0}
//   sym_i, sym_q   integrated I/Q of the emitted symbol
//   sync_locked    lock qualified
//   overflow       one-cycle pulse when an unaccepted symbol is overwritten
//   timing_acc     signed timing-error accumulator (debug)

module qpsk_symbol_sync #(
    parameter int SPS        = 16,
    parameter int ACC_W      = 40,
    parameter int TED_THRESH = 8,
    parameter int LOCK_CNT   = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [31:0]      i_in,
    input  logic signed [31:0]      q_in,
    input  logic                    sample_en,
    input  logic                    carrier_locked,
    input  logic                    sym_ready,
    output logic                    sym_valid,
    output logic [1:0]              sym_data,
    output logic signed [ACC_W-1:0] sym_i,
    output logic signed [ACC_W-1:0] sym_q,
    output logic                    sync_locked,
    output logic                    overflow,
    output logic signed [7:0]       timing_acc
);

    localparam int CNT_W = $clog2(SPS + 2);
    localparam int LCK_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] PER_NOM   = CNT_W'(SPS);
    localparam logic [CNT_W-1:0] PER_EARLY = CNT_W'(SPS + 1);
    localparam logic [CNT_W-1:0] PER_LATE  = CNT_W'(SPS - 1);
    localparam logic [LCK_W-1:0] LOCK_MAX  = LCK_W'(LOCK_CNT);

    localparam logic signed [7:0] POS_TH = 8'(TED_THRESH);
    localparam logic signed [7:0] NEG_TH = -8'(TED_THRESH);

    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        period;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    // Sign flags below are stored as "is negative" (1 = -1, 0 = +1).
    logic                    bnd_i;
    logic                    bnd_q;
    logic                    prev_i;
    logic                    prev_q;
    logic                    prev_valid;
    logic [LCK_W-1:0]        lock_cnt;

    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic                    dump;
    logic                    cur_i;
    logic                    cur_q;
    logic signed [7:0]       ted_sum;

    // One Gardner term: (sgn(prev) - sgn(cur)) * sgn(bnd), all in {+1,-1}.
    function automatic logic signed [7:0] ted_term(input logic p, input logic c, input logic b);
        logic signed [7:0] d;
        d = '0;
        if (p != c) begin
            d = p ? -8'sd2 : 8'sd2;
        end
        return b ? -d : d;
    endfunction

    always_comb begin
        sum_i   = acc_i + ACC_W'(i_in);
        sum_q   = acc_q + ACC_W'(q_in);
        dump    = sample_en && (cnt == period - CNT_W'(1));
        cur_i   = sum_i[ACC_W-1];
        cur_q   = sum_q[ACC_W-1];
        ted_sum = timing_acc + ted_term(prev_i, cur_i, bnd_i)
                             + ted_term(prev_q, cur_q, bnd_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            period      <= PER_NOM;
            acc_i       <= '0;
            acc_q       <= '0;
            bnd_i       <= 1'b0;
            bnd_q       <= 1'b0;
            prev_i      <= 1'b0;
            prev_q      <= 1'b0;
            prev_valid  <= 1'b0;
            lock_cnt    <= '0;
            sym_valid   <= 1'b0;
            sym_data    <= '0;
            sym_i       <= '0;
            sym_q       <= '0;
            sync_locked <= 1'b0;
            overflow    <= 1'b0;
            timing_acc  <= '0;
        end else begin
            overflow <= 1'b0;
            if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end

            if (sample_en) begin
                if (cnt == '0) begin
                    bnd_i <= i_in[31];
                    bnd_q <= q_in[31];
                end
                if (dump) begin
                    acc_i      <= '0;
                    acc_q      <= '0;
                    cnt        <= '0;
                    prev_i     <= cur_i;
                    prev_q     <= cur_q;
                    prev_valid <= 1'b1;
                    period     <= PER_NOM;
                    // The first dump after reset only seeds prev_*.
                    if (prev_valid) begin
                        if (ted_sum >= POS_TH) begin
                            period     <= PER_EARLY;
                            timing_acc <= '0;
                        end else if (ted_sum <= NEG_TH) begin
                            period     <= PER_LATE;
                            timing_acc <= '0;
                        end else begin
                            timing_acc <= ted_sum;
                        end
                    end
                    // Emission uses the lock state before this cycle's update.
                    if (sync_locked) begin
                        sym_i     <= sum_i;
                        sym_q     <= sum_q;
                        sym_data  <= {cur_i, cur_q};
                        sym_valid <= 1'b1;
                        overflow  <= sym_valid && !sym_ready;
                    end
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + CNT_W'(1);
                end
            end

            if (!carrier_locked) begin
                lock_cnt    <= '0;
                sync_locked <= 1'b0;
            end else begin
                if (dump && (lock_cnt != LOCK_MAX)) begin
                    lock_cnt <= lock_cnt + LCK_W'(1);
                end
                sync_locked <= (lock_cnt == LOCK_MAX);
            end
        end
    end

endmodule
